// File: rtl/uart_tx_seq_pkg.sv
// Shared types and helpers for the UART result sequencer.
package uart_tx_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StWaitAlu  = 4'd1,
    StLoad     = 4'd2,
    StSend     = 4'd3,
    StWaitAck  = 4'd4,
    StWaitDone = 4'd5,
    StGap      = 4'd6,
    StDone     = 4'd7
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uart_tx_result_sequencer_cycle_counter.sv
// Shared up-counter with synchronous clear and terminal-count flag against a runtime limit.
module cycle_counter #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Terminal on the last cycle of a limit-long window that started at count 0.
  assign o_tc = (r_count == (i_limit - WIDTH'(1)));

endmodule

// File: rtl/uart_tx_result_sequencer.sv
// Sends a snapshotted ALU result LSB-first over a UART TX using a start/busy handshake.
module uart_tx_result_sequencer
  import uart_tx_seq_pkg::*;
#(
  parameter int unsigned DELAY_FOR_ALU    = 100,
  parameter int unsigned INTER_BYTE_DELAY = 1000000,
  parameter int unsigned N_BYTES          = 2,
  parameter int unsigned ACK_TIMEOUT      = 1000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_trigger_tx_result,
  input  logic [8*N_BYTES-1:0]  i_result,
  input  logic                  i_tx_busy,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_tx_error,
  output logic [3:0]            o_stateID
);

  localparam int unsigned MAX_CNT = max3(DELAY_FOR_ALU, INTER_BYTE_DELAY, ACK_TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  state_e                r_state;
  logic [8*N_BYTES-1:0]  r_snap;
  logic [IDX_W-1:0]      r_byte_idx;
  logic [BYTE_W-1:0]     r_tx_data;
  logic                  r_tx_start;
  logic                  r_done;
  logic                  r_tx_error;
  logic                  r_pending;

  logic                  w_cnt_en;
  logic                  w_cnt_clr;
  logic                  w_tc;
  logic [CNT_W-1:0]      w_limit;

  always_comb begin
    w_limit  = CNT_W'(1);
    w_cnt_en = 1'b0;
    case (r_state)
      StWaitAlu: begin
        w_limit  = CNT_W'(DELAY_FOR_ALU);
        w_cnt_en = 1'b1;
      end
      StWaitAck: begin
        w_limit  = CNT_W'(ACK_TIMEOUT);
        w_cnt_en = 1'b1;
      end
      StGap: begin
        w_limit  = CNT_W'(INTER_BYTE_DELAY);
        w_cnt_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Timed states never follow each other directly, so holding the counter at zero
  // outside them guarantees it starts from zero on every entry.
  assign w_cnt_clr = ~w_cnt_en | w_tc;

  cycle_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_counter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_cnt_clr),
    .i_enable (w_cnt_en),
    .i_limit  (w_limit),
    .o_tc     (w_tc)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_snap     <= '0;
      r_byte_idx <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      r_tx_error <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      if (i_trigger_tx_result && (r_state != StIdle)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (i_trigger_tx_result || r_pending) begin
            r_state    <= StWaitAlu;
            r_pending  <= 1'b0;
            r_byte_idx <= '0;
            r_tx_error <= 1'b0;
          end
        end
        StWaitAlu: begin
          if (w_tc) r_state <= StLoad;
        end
        StLoad: begin
          r_snap     <= i_result;
          r_tx_data  <= i_result[BYTE_W-1:0];
          r_tx_start <= 1'b1;
          r_state    <= StSend;
        end
        StSend: begin
          r_state <= StWaitAck;
        end
        StWaitAck: begin
          if (i_tx_busy) begin
            r_state <= StWaitDone;
          end else if (w_tc) begin
            r_tx_error <= 1'b1;
            r_state    <= StIdle;
          end
        end
        StWaitDone: begin
          if (!i_tx_busy) begin
            if (r_byte_idx == IDX_W'(N_BYTES - 1)) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_byte_idx <= r_byte_idx + IDX_W'(1);
              r_state    <= StGap;
            end
          end
        end
        StGap: begin
          if (w_tc) begin
            r_tx_data  <= r_snap[BYTE_W*int'(r_byte_idx) +: BYTE_W];
            r_tx_start <= 1'b1;
            r_state    <= StSend;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_done     = r_done;
  assign o_tx_error = r_tx_error;
  assign o_busy     = (r_state != StIdle);
  assign o_stateID  = r_state;

endmodule
